uc_bcast_ctrl: RTL and testbench

UC_BCAST_CTRL -- requirements
Module: uc_bcast_ctrl

---
 rtl/uc_bcast_ctrl_pkg.sv | 14 +
 rtl/uc_bcast_ctrl_stall_timer.sv | 24 ++
 rtl/uc_bcast_ctrl.sv | 108 ++++++++++
 tb/tb_uc_bcast_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uc_bcast_ctrl_pkg.sv
// Shared types and default sizing for the UC broadcast controller.
package uc_pkg;
  localparam int UC_LENGTH  = 1024;
  localparam int NUM_ENGINE = 4;
  localparam int UC_W       = $clog2(UC_LENGTH);

  typedef logic signed [UC_W-1:0] uc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BCAST,
    ST_HALT
  } uc_bcast_state_t;
endpackage

// File: rtl/uc_bcast_ctrl_stall_timer.sv
// No-progress cycle counter; expired is combinational on the cycle that reaches limit.
module uc_stall_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   next_cnt;

  // One extra bit so an all-ones count cannot wrap past the limit.
  assign next_cnt = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign expired  = inc && (next_cnt >= {1'b0, limit});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= next_cnt[CNT_W-1:0];
  end
endmodule

// File: rtl/uc_bcast_ctrl.sv
// Pops UCs from the central queue and delivers each exactly once to every engine,
// tracking per-engine pending bits; halts on arbiter conflict or on a delivery stall.
module uc_bcast_ctrl #(
  parameter int  NUM_ENGINE = uc_pkg::NUM_ENGINE,
  parameter int  UC_LENGTH  = uc_pkg::UC_LENGTH,
  parameter int  STALL_MAX  = 255,
  localparam int UC_W       = $clog2(UC_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   conflict,
  input  logic                   ucq_empty,
  input  logic signed [UC_W-1:0] ucq_data,
  output logic                   ucq_pop,
  input  logic [NUM_ENGINE-1:0]  eng_full,
  output logic [NUM_ENGINE-1:0]  eng_push,
  output logic signed [UC_W-1:0] eng_data,
  output logic                   busy,
  output logic                   halted,
  output logic                   stall_err,
  output logic [15:0]            bcast_cnt
);
  import uc_pkg::uc_bcast_state_t;
  import uc_pkg::ST_IDLE;
  import uc_pkg::ST_BCAST;
  import uc_pkg::ST_HALT;

  uc_bcast_state_t         state;
  logic [NUM_ENGINE-1:0]   pending;
  logic [NUM_ENGINE-1:0]   push_raw;
  logic signed [UC_W-1:0]  uc_r;
  logic                    blocked;
  logic                    load_ok;
  logic                    last;
  logic                    stall_inc;
  logic                    expired;

  always_comb begin
    blocked   = conflict | flush;
    push_raw  = (state == ST_BCAST) ? (pending & ~eng_full) : '0;
    eng_push  = (blocked || !rst) ? '0 : push_raw;
    // Final delivery: every still-pending engine can take the word this cycle.
    last      = (state == ST_BCAST) && !blocked && ((pending & eng_full) == '0);
    load_ok   = enable && !ucq_empty && !blocked;
    ucq_pop   = rst && load_ok && ((state == ST_IDLE) || last);
    stall_inc = (state == ST_BCAST) && !blocked && (eng_push == '0);
  end

  uc_stall_timer #(.CNT_W(16)) u_stall (
    .clk     (clk),
    .rst     (rst),
    .inc     (stall_inc),
    .clr     (!stall_inc),
    .limit   (16'(STALL_MAX)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pending   <= '0;
      uc_r      <= '0;
      stall_err <= 1'b0;
      bcast_cnt <= '0;
    end else if (conflict) begin
      state <= ST_HALT;
    end else if (flush) begin
      state     <= ST_IDLE;
      pending   <= '0;
      stall_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_ok) begin
            uc_r    <= ucq_data;
            pending <= '1;
            state   <= ST_BCAST;
          end
        end
        ST_BCAST: begin
          if (last) begin
            bcast_cnt <= bcast_cnt + 16'd1;
            if (load_ok) begin
              uc_r    <= ucq_data;
              pending <= '1;
            end else begin
              pending <= '0;
              state   <= ST_IDLE;
            end
          end else begin
            pending <= pending & ~push_raw;
            if (expired) begin
              stall_err <= 1'b1;
              state     <= ST_HALT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_data = uc_r;
  assign busy     = (state == ST_BCAST);
  assign halted   = (state == ST_HALT);
endmodule

// File: tb/tb_uc_bcast_ctrl.sv
// Directed plus random stimulus for uc_bcast_ctrl against a per-engine delivery model.
module tb_uc_bcast_ctrl;
  localparam int NE  = 4;
  localparam int UCL = 1024;
  localparam int SM  = 4;
  localparam int W   = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable = 1'b0;
  logic                flush = 1'b0;
  logic                conflict = 1'b0;
  logic                ucq_empty;
  logic signed [W-1:0] ucq_data;
  logic                ucq_pop;
  logic [NE-1:0]       eng_full = '0;
  logic [NE-1:0]       eng_push;
  logic signed [W-1:0] eng_data;
  logic                busy;
  logic                halted;
  logic                stall_err;
  logic [15:0]         bcast_cnt;

  always #5 clk = ~clk;

  uc_bcast_ctrl #(.NUM_ENGINE(NE), .UC_LENGTH(UCL), .STALL_MAX(SM)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .conflict(conflict),
    .ucq_empty(ucq_empty), .ucq_data(ucq_data), .ucq_pop(ucq_pop),
    .eng_full(eng_full), .eng_push(eng_push), .eng_data(eng_data),
    .busy(busy), .halted(halted), .stall_err(stall_err), .bcast_cnt(bcast_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] q[$];

  // Model: mode 0 idle, 1 broadcasting, 2 halted; got[i] = engine i already has m_uc.
  int                  mode;
  logic signed [W-1:0] m_uc;
  logic [NE-1:0]       got;
  int                  idle;
  logic                m_stall;
  logic [15:0]         m_cnt;
  logic [NE-1:0]       obs_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_q();
    ucq_empty = (q.size() == 0);
    ucq_data  = (q.size() == 0) ? '0 : q[0];
  endtask

  task automatic model_reset();
    mode = 0; m_uc = '0; got = '1; idle = 0; m_stall = 1'b0; m_cnt = '0;
  endtask

  task automatic step(input logic en, input logic fl, input logic cf, input logic [NE-1:0] full);
    logic [NE-1:0] e_push;
    logic          done, load, e_pop;
    @(negedge clk);
    enable = en; flush = fl; conflict = cf; eng_full = full;
    drive_q();
    #1;
    e_push = '0;
    for (int i = 0; i < NE; i++)
      if (mode == 1 && !cf && !fl && !got[i] && !full[i]) e_push[i] = 1'b1;
    done  = (mode == 1) && !cf && !fl && ((got | e_push) == '1);
    load  = en && (q.size() > 0) && !cf && !fl;
    e_pop = load && (mode == 0 || done);
    obs_push = eng_push;
    chk("eng_push", 32'(eng_push), 32'(e_push));
    chk("ucq_pop", 32'(ucq_pop), 32'(e_pop));
    chk("busy", 32'(busy), 32'(mode == 1));
    chk("halted", 32'(halted), 32'(mode == 2));
    chk("stall_err", 32'(stall_err), 32'(m_stall));
    chk("bcast_cnt", 32'(bcast_cnt), 32'(m_cnt));
    chk("eng_data", 32'(eng_data), 32'(m_uc));
    if (cf) begin
      mode = 2; idle = 0;
    end else if (fl) begin
      mode = 0; got = '1; idle = 0; m_stall = 1'b0;
    end else if (mode == 0) begin
      if (load) begin m_uc = q[0]; got = '0; mode = 1; end
    end else if (mode == 1) begin
      got = got | e_push;
      if (done) begin
        m_cnt = m_cnt + 16'd1; idle = 0;
        if (load) begin m_uc = q[0]; got = '0; end
        else mode = 0;
      end else begin
        idle = (e_push == '0) ? idle + 1 : 0;
        if (idle == SM) begin m_stall = 1'b1; mode = 2; idle = 0; end
      end
    end
    @(posedge clk);
    if (e_pop && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    enable = 1'b0; flush = 1'b0; conflict = 1'b0; eng_full = '0;
    #1;
    chk("rst_push", 32'(eng_push), 32'd0);
    chk("rst_pop", 32'(ucq_pop), 32'd0);
    chk("rst_data", 32'(eng_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall", 32'(stall_err), 32'd0);
    chk("rst_cnt", 32'(bcast_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    drive_q();
    do_reset();

    // Back-to-back broadcast of two queued UCs.
    q.push_back(10'sd5); q.push_back(-10'sd3);
    step(1, 0, 0, 4'b0000);
    step(1, 0, 0, 4'b0000);
    chk("b2b_first", 32'(obs_push), 32'(4'b1111));
    step(1, 0, 0, 4'b0000);
    step(1, 0, 0, 4'b0000);
    #1 chk("b2b_cnt", 32'(bcast_cnt), 32'd2);

    // Engine 2 full for three cycles: it gets the UC once, later.
    q.push_back(10'sd7);
    step(1, 0, 0, 4'b0000);
    step(1, 0, 0, 4'b0100);
    chk("partial_push", 32'(obs_push), 32'(4'b1011));
    step(1, 0, 0, 4'b0100);
    step(1, 0, 0, 4'b0100);
    #1 chk("partial_cnt_hold", 32'(bcast_cnt), 32'd2);
    step(1, 0, 0, 4'b0000);
    chk("late_push", 32'(obs_push), 32'(4'b0100));
    #1 chk("partial_cnt", 32'(bcast_cnt), 32'd3);

    // Engine 0 stuck full: stall error after SM idle cycles, then flush.
    q.push_back(10'sd9);
    step(1, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 4'b0001);
    #1 chk("stall_halt", 32'({halted, stall_err}), 32'(2'b11));
    step(1, 1, 0, 4'b0001);
    #1 chk("stall_flush", 32'({halted, stall_err, busy}), 32'd0);

    // Conflict mid-broadcast, then flush and conflict together.
    q.push_back(10'sd11);
    step(1, 0, 0, 4'b0000);
    step(1, 0, 0, 4'b1100);
    step(1, 0, 1, 4'b0000);
    chk("conflict_push", 32'(obs_push), 32'd0);
    step(1, 1, 1, 4'b0000);
    #1 chk("conflict_wins", 32'(halted), 32'd1);
    step(0, 1, 0, 4'b0000);

    // Reset with engines 1 and 2 still pending drops the UC.
    q.push_back(10'sd13);
    step(1, 0, 0, 4'b0000);
    step(1, 0, 0, 4'b0110);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0000);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [NE-1:0] full;
      if ($urandom_range(2) == 0) q.push_back(W'($urandom));
      for (int i = 0; i < NE; i++) full[i] = ($urandom_range(3) == 0);
      if ($urandom_range(30) == 0) full = '1;
      if ($urandom_range(200) == 0) do_reset();
      step($urandom_range(3) != 0, $urandom_range(40) == 0, $urandom_range(60) == 0, full);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
